multi_sum_accum: RTL and testbench

MULTI_SUM_ACCUM -- requirements
Module: multi_sum_accum

---
 rtl/multi_sum_accum.sv | 93 +++++++++
 tb/tb_multi_sum_accum.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_sum_accum.sv
// multi_sum_accum: per-channel accumulators fed by a valid/ready request port.
// Each accepted request produces one registered result on a valid/ready output.
module multi_sum_accum #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter bit SATURATE = 1'b0,
    localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CHAN_W-1:0] in_chan,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic              in_clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CHAN_W-1:0] out_chan,
    output logic [WIDTH-1:0]  out_sum,
    output logic              out_ovf
);

    localparam logic [CHAN_W:0]  NUM_CH   = (CHAN_W + 1)'(CHANNELS);
    localparam logic [WIDTH+1:0] MAX_FULL = {2'b00, {WIDTH{1'b1}}};

    logic [WIDTH-1:0] acc [CHANNELS];

    logic             accept;
    logic             legal;
    logic             load;
    logic [WIDTH-1:0] cur;
    logic [WIDTH+1:0] full;
    logic [WIDTH-1:0] nxt;
    logic             ovf;

    // The result slot frees up when empty or being drained this cycle.
    assign in_ready = !reset && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign legal    = {1'b0, in_chan} < NUM_CH;
    assign load     = accept && legal;

    // Select the addressed accumulator; out-of-range indices read as zero.
    always_comb begin
        cur = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (in_chan == CHAN_W'(c)) begin
                cur = acc[c];
            end
        end
    end

    // Two guard bits hold the worst case acc + a + b without loss.
    always_comb begin
        full = {2'b00, cur} + {2'b00, in_a} + {2'b00, in_b};
        ovf  = full > MAX_FULL;
        nxt  = full[WIDTH-1:0];
        if (in_clear) begin
            nxt = '0;
            ovf = 1'b0;
        end else if (SATURATE && ovf) begin
            nxt = '1;
        end
    end

    // Accumulator bank and registered result slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c] <= '0;
            end
            out_valid <= 1'b0;
            out_chan  <= '0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (load && in_chan == CHAN_W'(c)) begin
                    acc[c] <= nxt;
                end
            end
            if (load) begin
                out_valid <= 1'b1;
                out_chan  <= in_chan;
                out_sum   <= nxt;
                out_ovf   <= ovf;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multi_sum_accum.sv
// tb_multi_sum_accum: three configurations share one stimulus stream
// and are checked against a per-instance arithmetic reference model.
module tb_multi_sum_accum;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset     = 1'b1;
    logic       in_valid  = 1'b0;
    logic       in_clear  = 1'b0;
    logic       out_ready = 1'b0;
    logic [1:0] chan      = 2'd0;
    logic [7:0] in_a      = 8'd0;
    logic [7:0] in_b      = 8'd0;

    logic       ir0, ir1, ir2, ov0, ov1, ov2, of0, of1, of2;
    logic       oc0, oc1;
    logic [1:0] oc2;
    logic [7:0] os0, os1, os2;

    logic       ir [3];
    logic       ov [3];
    logic       of [3];
    logic [1:0] oc [3];
    logic [7:0] os [3];

    assign ir[0] = ir0;
    assign ir[1] = ir1;
    assign ir[2] = ir2;
    assign ov[0] = ov0;
    assign ov[1] = ov1;
    assign ov[2] = ov2;
    assign of[0] = of0;
    assign of[1] = of1;
    assign of[2] = of2;
    assign oc[0] = {1'b0, oc0};
    assign oc[1] = {1'b0, oc1};
    assign oc[2] = oc2;
    assign os[0] = os0;
    assign os[1] = os1;
    assign os[2] = os2;

    // Defaults: WIDTH 8, two channels, wrap.
    multi_sum_accum dut_def (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(ir0),
        .in_chan(chan[0]), .in_a(in_a), .in_b(in_b),
        .in_clear(in_clear),
        .out_valid(ov0), .out_ready(out_ready),
        .out_chan(oc0), .out_sum(os0), .out_ovf(of0)
    );

    multi_sum_accum #(.WIDTH(8), .CHANNELS(2), .SATURATE(1'b1)) dut_sat (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(ir1),
        .in_chan(chan[0]), .in_a(in_a), .in_b(in_b),
        .in_clear(in_clear),
        .out_valid(ov1), .out_ready(out_ready),
        .out_chan(oc1), .out_sum(os1), .out_ovf(of1)
    );

    multi_sum_accum #(.WIDTH(8), .CHANNELS(3), .SATURATE(1'b0)) dut_c3 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(ir2),
        .in_chan(chan), .in_a(in_a), .in_b(in_b),
        .in_clear(in_clear),
        .out_valid(ov2), .out_ready(out_ready),
        .out_chan(oc2), .out_sum(os2), .out_ovf(of2)
    );

    int macc  [3][4];
    bit mv    [3];
    int mchan [3];
    int msum  [3];
    bit movf  [3];
    int nch   [3] = '{2, 2, 3};
    int cmask [3] = '{1, 1, 3};
    bit sat   [3] = '{1'b0, 1'b1, 1'b0};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic drive(input bit v, input logic [1:0] c,
                         input logic [7:0] a, input logic [7:0] b,
                         input bit clr, input bit ordy);
        in_valid  = v;
        chan      = c;
        in_a      = a;
        in_b      = b;
        in_clear  = clr;
        out_ready = ordy;
    endtask

    // Advance the reference model by one cycle, then clock the DUTs.
    task automatic tick();
        for (int i = 0; i < 3; i++) begin
            int  idx;
            int  full;
            bit  rdy;
            idx = int'(chan) & cmask[i];
            rdy = !mv[i] || out_ready;
            if (reset) begin
                for (int c = 0; c < 4; c++) macc[i][c] = 0;
                mv[i]    = 1'b0;
                mchan[i] = 0;
                msum[i]  = 0;
                movf[i]  = 1'b0;
            end else if (in_valid && rdy && idx < nch[i]) begin
                full = macc[i][idx] + int'(in_a) + int'(in_b);
                if (in_clear) begin
                    macc[i][idx] = 0;
                    movf[i]      = 1'b0;
                end else begin
                    movf[i] = full >= 256;
                    if (sat[i]) macc[i][idx] = (full > 255) ? 255 : full;
                    else        macc[i][idx] = full % 256;
                end
                mv[i]    = 1'b1;
                mchan[i] = idx;
                msum[i]  = macc[i][idx];
            end else if (out_ready) begin
                mv[i] = 1'b0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 2'd0, 8'd5, 8'd5, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (ir[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_ready[%0d]: got %b want 0", i, ir[i]);
            end
        end
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({ov[i], of[i], oc[i], os[i]} !== 12'd0) begin
                n_fail++;
                $display("FAIL rst_out[%0d]: got v%b o%b c%0d s%0d want 0",
                         i, ov[i], of[i], oc[i], os[i]);
            end
        end
        reset = 1'b0;
        drive(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_defaults();
        drive(1'b1, 2'd0, 8'd1, 8'd2, 1'b0, 1'b1);
        #1;
        n_tests++;
        if (ir0 !== 1'b1) begin
            n_fail++;
            $display("FAIL def_ready: got %b want 1", ir0);
        end
        tick();
        n_tests++;
        if ({ov0, oc0, os0, of0} !== {1'b1, 1'b0, 8'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL def_add3: got v%b c%0d s%0d o%b want v1 c0 s3 o0",
                     ov0, oc0, os0, of0);
        end
        drive(1'b1, 2'd0, 8'd3, 8'd4, 1'b0, 1'b1);
        tick();
        n_tests++;
        if ({ov0, os0} !== {1'b1, 8'd10}) begin
            n_fail++;
            $display("FAIL def_chain10: got v%b s%0d want v1 s10", ov0, os0);
        end
        drive(1'b1, 2'd1, 8'd0, 8'd0, 1'b0, 1'b1);
        tick();
        n_tests++;
        if ({ov0, oc0, os0} !== {1'b1, 1'b1, 8'd0}) begin
            n_fail++;
            $display("FAIL def_ch1_zero: got v%b c%0d s%0d want v1 c1 s0",
                     ov0, oc0, os0);
        end
        drive(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        tick();
        n_tests++;
        if (ov0 !== 1'b0) begin
            n_fail++;
            $display("FAIL def_drain: got v%b want v0", ov0);
        end
    endtask

    task automatic test_wrap();
        drive(1'b1, 2'd1, 8'd200, 8'd50, 1'b0, 1'b1);
        tick();
        n_tests++;
        if ({os0, of0, os1, of1} !== {8'd250, 1'b0, 8'd250, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_250: got %0d/%b sat %0d/%b want 250/0",
                     os0, of0, os1, of1);
        end
        drive(1'b1, 2'd1, 8'd10, 8'd0, 1'b0, 1'b1);
        tick();
        n_tests++;
        if ({os0, of0} !== {8'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap_4: got %0d/%b want 4/1", os0, of0);
        end
        n_tests++;
        if ({os1, of1} !== {8'd255, 1'b1}) begin
            n_fail++;
            $display("FAIL sat_clamp_ch1: got %0d/%b want 255/1", os1, of1);
        end
        drive(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_saturate();
        drive(1'b1, 2'd0, 8'd255, 8'd255, 1'b0, 1'b1);
        tick();
        n_tests++;
        if ({ov1, os1, of1} !== {1'b1, 8'd255, 1'b1}) begin
            n_fail++;
            $display("FAIL sat_max: got v%b %0d/%b want v1 255/1",
                     ov1, os1, of1);
        end
        n_tests++;
        if ({os0, of0} !== {8'd8, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap_520: got %0d/%b want 8/1", os0, of0);
        end
        drive(1'b1, 2'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        tick();
        n_tests++;
        if ({os1, of1} !== {8'd255, 1'b0}) begin
            n_fail++;
            $display("FAIL sat_hold: got %0d/%b want 255/0", os1, of1);
        end
        drive(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_backpressure();
        drive(1'b1, 2'd0, 8'd1, 8'd1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'd1, 8'd7, 8'd7, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (ir[i] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_ready[%0d] k%0d: got %b want 0",
                             i, k, ir[i]);
                end
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if ({ov[i], oc[i], os[i], of[i]} !==
                    {1'b1, 2'(mchan[i]), 8'(msum[i]), movf[i]}) begin
                    n_fail++;
                    $display("FAIL bp_hold[%0d] k%0d: got v%b c%0d s%0d o%b want v1 c%0d s%0d o%b",
                             i, k, ov[i], oc[i], os[i], of[i],
                             mchan[i], msum[i], movf[i]);
                end
            end
        end
        n_tests++;
        if (os0 !== 8'd10) begin
            n_fail++;
            $display("FAIL bp_value: got %0d want 10", os0);
        end
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (ir0 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b want 1", ir0);
        end
        tick();
        n_tests++;
        if ({ov0, oc0, os0} !== {1'b1, 1'b1, 8'd18}) begin
            n_fail++;
            $display("FAIL bp_no_gap: got v%b c%0d s%0d want v1 c1 s18",
                     ov0, oc0, os0);
        end
        drive(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_clear_illegal();
        drive(1'b1, 2'd2, 8'd5, 8'd5, 1'b0, 1'b1);
        tick();
        n_tests++;
        if ({ov2, oc2, os2} !== {1'b1, 2'd2, 8'd10}) begin
            n_fail++;
            $display("FAIL c3_add10: got v%b c%0d s%0d want v1 c2 s10",
                     ov2, oc2, os2);
        end
        drive(1'b1, 2'd2, 8'd9, 8'd9, 1'b1, 1'b1);
        tick();
        n_tests++;
        if ({ov2, os2, of2} !== {1'b1, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL c3_clear: got v%b s%0d o%b want v1 s0 o0",
                     ov2, os2, of2);
        end
        drive(1'b1, 2'd3, 8'd4, 8'd4, 1'b0, 1'b1);
        tick();
        n_tests++;
        if (ov2 !== 1'b0) begin
            n_fail++;
            $display("FAIL c3_illegal: got v%b want v0", ov2);
        end
        drive(1'b1, 2'd2, 8'd1, 8'd1, 1'b0, 1'b1);
        tick();
        n_tests++;
        if ({ov2, os2} !== {1'b1, 8'd2}) begin
            n_fail++;
            $display("FAIL c3_after_clear: got v%b s%0d want v1 s2", ov2, os2);
        end
        drive(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  8'($urandom), 8'($urandom),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
            #1;
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (ir[i] !== (!mv[i] || out_ready)) begin
                    n_fail++;
                    $display("FAIL rnd_ready[%0d] n%0d: got %b", i, n, ir[i]);
                end
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (ov[i] !== mv[i]) begin
                    n_fail++;
                    $display("FAIL rnd_valid[%0d] n%0d: got %b want %b",
                             i, n, ov[i], mv[i]);
                end else if (mv[i] && {oc[i], os[i], of[i]} !==
                             {2'(mchan[i]), 8'(msum[i]), movf[i]}) begin
                    n_fail++;
                    $display("FAIL rnd_data[%0d] n%0d: got c%0d s%0d o%b want c%0d s%0d o%b",
                             i, n, oc[i], os[i], of[i],
                             mchan[i], msum[i], movf[i]);
                end
            end
        end
        drive(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 2'd1, 8'd3, 8'd3, 1'b0, 1'b1);
        tick();
        drive(1'b1, 2'd0, 8'd9, 8'd9, 1'b0, 1'b0);
        tick();
        n_tests++;
        if ({ov0, ov1, ov2} !== 3'b111) begin
            n_fail++;
            $display("FAIL mid_held: got %b%b%b want 111", ov0, ov1, ov2);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if ({ov0, ov1, ov2} !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_discard: got %b%b%b want 000", ov0, ov1, ov2);
        end
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 2'(c), 8'd0, 8'd0, 1'b0, 1'b1);
            tick();
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if ({ov[i], os[i], of[i]} !== {1'b1, 8'd0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL mid_zero[%0d] ch%0d: got v%b s%0d o%b want v1 s0 o0",
                             i, c, ov[i], os[i], of[i]);
                end
            end
        end
        drive(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 4; c++) macc[i][c] = 0;
            mv[i]    = 1'b0;
            mchan[i] = 0;
            msum[i]  = 0;
            movf[i]  = 1'b0;
        end
        test_reset();
        test_defaults();
        test_wrap();
        test_saturate();
        test_backpressure();
        test_clear_illegal();
        test_random();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
